// File: rtl/blink_pkg.sv
// blink_pkg: state encoding and half-period bound helpers shared by the blinker and its monitor.
package blink_pkg;

    typedef enum logic [1:0] {SEEK, MEASURE, LOCKED, STUCK} state_t;

    localparam int CBITS_DEF  = 12;
    localparam int TOL_DEF    = 2;
    localparam int LOCK_N_DEF = 4;

    function automatic int half_of(input int cbits);
        return 1 << cbits;
    endfunction

    function automatic int lo_of(input int cbits, input int tol);
        return half_of(cbits) - tol;
    endfunction

    function automatic int hi_of(input int cbits, input int tol);
        return half_of(cbits) + tol;
    endfunction

endpackage

// File: rtl/blink_sync.sv
// blink_sync: three-flop synchroniser for an asynchronous line, with a transition strobe.
module blink_sync (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic edge_det
);

    logic s1, s2, s3;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) {s1, s2, s3} <= 3'b000;
        else     {s1, s2, s3} <= {d, s1, s2};
    end

    assign edge_det = s2 ^ s3;

endmodule

// File: rtl/blink_monitor.sv
// blink_monitor: measures LED transition spacing and reports lock, errors and a stuck line.
module blink_monitor
    import blink_pkg::*;
#(
    parameter int CBITS  = CBITS_DEF,
    parameter int TOL    = TOL_DEF,
    parameter int LOCK_N = LOCK_N_DEF
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           led_in,
    output logic           toggle,
    output logic           err,
    output logic           locked,
    output logic           stuck,
    output logic [CBITS:0] half_period
);

    localparam int MW = $clog2(LOCK_N + 1);
    localparam logic [CBITS:0] LO      = (CBITS + 1)'(lo_of(CBITS, TOL));
    localparam logic [CBITS:0] HI      = (CBITS + 1)'(hi_of(CBITS, TOL));
    localparam logic [CBITS:0] CNT_ONE = (CBITS + 1)'(1);
    localparam logic [MW-1:0]  MMAX    = MW'(LOCK_N);

    state_t         state;
    logic [CBITS:0] cnt;
    logic [MW-1:0]  match;
    logic [MW-1:0]  match_inc;
    logic           edge_det;
    logic           hit;

    blink_sync u_sync (
        .clk      (clk),
        .rst      (rst),
        .d        (led_in),
        .edge_det (edge_det)
    );

    assign hit       = (cnt >= LO) && (cnt <= HI);
    assign match_inc = (match == MMAX) ? MMAX : match + MW'(1);

    // cnt saturates at HI so an idle line in SEEK never wraps into a false match
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= SEEK;
            cnt         <= '0;
            match       <= '0;
            toggle      <= 1'b0;
            err         <= 1'b0;
            locked      <= 1'b0;
            stuck       <= 1'b0;
            half_period <= '0;
        end else begin
            toggle <= edge_det;
            err    <= 1'b0;
            cnt    <= edge_det ? CNT_ONE : (state == STUCK || cnt == HI) ? cnt : cnt + CNT_ONE;
            if (state == SEEK || state == STUCK) begin
                if (edge_det) begin
                    state  <= MEASURE;
                    match  <= '0;
                    locked <= 1'b0;
                    stuck  <= 1'b0;
                end
            end else if (edge_det) begin
                half_period <= cnt;
                if (hit) begin
                    match  <= match_inc;
                    state  <= (match_inc == MMAX) ? LOCKED : MEASURE;
                    locked <= (match_inc == MMAX);
                end else begin
                    err    <= 1'b1;
                    match  <= '0;
                    state  <= MEASURE;
                    locked <= 1'b0;
                end
            end else if (cnt == HI) begin
                state  <= STUCK;
                match  <= '0;
                locked <= 1'b0;
                stuck  <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_blink_monitor.sv
// tb_blink_monitor: directed scenarios for blink_monitor at CBITS=4 (HALF=16, TOL=2, LOCK_N=4).
module tb_blink_monitor;
    import blink_pkg::*;

    localparam int CB = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        led_in = 1'b0;
    logic        toggle, err, locked, stuck;
    logic [CB:0] half_period;

    int checks = 0, errors = 0;
    int tog_cnt = 0, err_cnt = 0, cyc = 0, last_tog = 0, gap = 0;
    logic        o_tog, o_err, o_lock, o_stuck;
    logic [CB:0] o_hp;

    blink_monitor #(.CBITS(CB), .TOL(2), .LOCK_N(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .led_in      (led_in),
        .toggle      (toggle),
        .err         (err),
        .locked      (locked),
        .stuck       (stuck),
        .half_period (half_period)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (toggle) begin
            tog_cnt++;
            gap = cyc - last_tog;
            last_tog = cyc;
        end
        if (err) err_cnt++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    // flips led_in n cycles after the previous flip and samples outputs in its toggle cycle
    task automatic iv(input int n);
        repeat (n - 3) @(posedge clk);
        #1 led_in = ~led_in;
        repeat (3) @(posedge clk);
        @(negedge clk);
        {o_tog, o_err, o_lock, o_stuck} = {toggle, err, locked, stuck};
        o_hp = half_period;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        led_in = 1'b0;
        @(negedge clk);
        checks++; if ({toggle, err, locked, stuck, half_period} !== '0) begin errors++; $display("FAIL reset_outputs got %b want 0", {toggle, err, locked, stuck, half_period}); end
        checks++; if (dut.state !== SEEK) begin errors++; $display("FAIL reset_state got %0d want %0d", dut.state, SEEK); end
        rst = 1'b0;
        repeat (50) @(negedge clk);
        #1;
        checks++; if ({toggle, err, locked, stuck, half_period} !== '0) begin errors++; $display("FAIL idle_outputs got %b want 0", {toggle, err, locked, stuck, half_period}); end
        checks++; if (tog_cnt !== 0) begin errors++; $display("FAIL idle_toggles got %0d want 0", tog_cnt); end
        checks++; if (dut.state !== SEEK) begin errors++; $display("FAIL idle_state got %0d want %0d", dut.state, SEEK); end
    endtask

    task automatic test_lock();
        iv(4);
        checks++; if (o_tog !== 1'b1) begin errors++; $display("FAIL lock_first_toggle got %b want 1", o_tog); end
        checks++; if (o_hp !== 5'd0) begin errors++; $display("FAIL lock_first_hp got %0d want 0", o_hp); end
        for (int i = 2; i <= 5; i++) begin
            iv(16);
            checks++; if (o_tog !== 1'b1) begin errors++; $display("FAIL lock_toggle_%0d got %b want 1", i, o_tog); end
            checks++; if (o_hp !== 5'd16) begin errors++; $display("FAIL lock_hp_%0d got %0d want 16", i, o_hp); end
            checks++; if (o_lock !== (i == 5)) begin errors++; $display("FAIL lock_locked_%0d got %b want %b", i, o_lock, i == 5); end
        end
        #1;
        checks++; if (gap !== 16) begin errors++; $display("FAIL lock_gap got %0d want 16", gap); end
        checks++; if (tog_cnt !== 5) begin errors++; $display("FAIL lock_tog_cnt got %0d want 5", tog_cnt); end
        checks++; if (err_cnt !== 0) begin errors++; $display("FAIL lock_err_cnt got %0d want 0", err_cnt); end
    endtask

    task automatic test_tolerance();
        iv(14);
        checks++; if ({o_lock, o_err, o_hp} !== {1'b1, 1'b0, 5'd14}) begin errors++; $display("FAIL tol14 got %b want %b", {o_lock, o_err, o_hp}, {1'b1, 1'b0, 5'd14}); end
        iv(18);
        checks++; if ({o_lock, o_err, o_hp} !== {1'b1, 1'b0, 5'd18}) begin errors++; $display("FAIL tol18 got %b want %b", {o_lock, o_err, o_hp}, {1'b1, 1'b0, 5'd18}); end
        iv(13);
        checks++; if ({o_lock, o_err, o_hp} !== {1'b0, 1'b1, 5'd13}) begin errors++; $display("FAIL tol13 got %b want %b", {o_lock, o_err, o_hp}, {1'b0, 1'b1, 5'd13}); end
        for (int i = 1; i <= 4; i++) begin
            iv(16);
            checks++; if ({o_lock, o_err} !== {i == 4, 1'b0}) begin errors++; $display("FAIL relock_%0d got %b want %b", i, {o_lock, o_err}, {i == 4, 1'b0}); end
        end
        #1;
        checks++; if (err_cnt !== 1) begin errors++; $display("FAIL tol_err_cnt got %0d want 1", err_cnt); end
    endtask

    task automatic test_boundary();
        iv(18);
        checks++; if ({o_lock, o_err, o_stuck, o_hp} !== {1'b1, 1'b0, 1'b0, 5'd18}) begin errors++; $display("FAIL edge_at_18 got %b want %b", {o_lock, o_err, o_stuck, o_hp}, {1'b1, 1'b0, 1'b0, 5'd18}); end
    endtask

    task automatic test_stuck();
        logic [CB:0] hp_before;
        int e0;
        hp_before = 5'd18;
        repeat (17) @(posedge clk);
        @(negedge clk);
        checks++; if ({stuck, locked} !== 2'b01) begin errors++; $display("FAIL stuck_early got %b want 01", {stuck, locked}); end
        @(negedge clk);
        checks++; if ({stuck, locked} !== 2'b10) begin errors++; $display("FAIL stuck_rise got %b want 10", {stuck, locked}); end
        repeat (10) @(negedge clk);
        #1;
        checks++; if ({stuck, locked} !== 2'b10) begin errors++; $display("FAIL stuck_hold got %b want 10", {stuck, locked}); end
        e0 = err_cnt;
        iv(5);
        checks++; if ({o_tog, o_stuck, o_lock, o_err} !== 4'b1000) begin errors++; $display("FAIL stuck_exit got %b want 1000", {o_tog, o_stuck, o_lock, o_err}); end
        checks++; if (o_hp !== hp_before) begin errors++; $display("FAIL stuck_exit_hp got %0d want %0d", o_hp, hp_before); end
        #1;
        checks++; if (err_cnt !== e0) begin errors++; $display("FAIL stuck_exit_err got %0d want %0d", err_cnt, e0); end
    endtask

    task automatic test_async_reset();
        int t0;
        for (int i = 1; i <= 4; i++) iv(16);
        checks++; if (o_lock !== 1'b1) begin errors++; $display("FAIL pre_reset_lock got %b want 1", o_lock); end
        #2;
        led_in = 1'b1;
        rst = 1'b1;
        #1;
        checks++; if ({toggle, err, locked, stuck, half_period} !== '0) begin errors++; $display("FAIL async_clear got %b want 0", {toggle, err, locked, stuck, half_period}); end
        checks++; if (dut.state !== SEEK) begin errors++; $display("FAIL async_state got %0d want %0d", dut.state, SEEK); end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1 t0 = tog_cnt;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++; if (toggle !== 1'b0) begin errors++; $display("FAIL release_early_toggle got %b want 0", toggle); end
        @(negedge clk);
        checks++; if ({toggle, err, locked, stuck} !== 4'b1000) begin errors++; $display("FAIL release_pulse got %b want 1000", {toggle, err, locked, stuck}); end
        checks++; if (dut.state !== MEASURE) begin errors++; $display("FAIL release_state got %0d want %0d", dut.state, MEASURE); end
        repeat (6) @(negedge clk);
        #1;
        checks++; if (tog_cnt !== t0 + 1) begin errors++; $display("FAIL release_tog_cnt got %0d want %0d", tog_cnt, t0 + 1); end
    endtask

    initial begin
        test_reset();
        test_lock();
        test_tolerance();
        test_boundary();
        test_stuck();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
